memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Pipeline MEM stage. Sits directly downstream of the execute stage.
//  Takes each execute result (ALU output, destination, control) and, for loads/stores, runs one
//  data-bus transaction. Sign- or zero-extends load data. Registers the result for writeback.
//  Uses valid/ready handshakes upstream and downstream; stalls upstream while a bus access is open.
// PARAMETERS
//  XLEN      64  datapath width; only 64 is supported
//  ADDR_W    64  data-bus address width
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       async reset, active-low
//  in_valid       in   1       execute result valid
//  in_ready       out  1       stage can accept a new result
//  in_aluout      in   XLEN    ALU result; the effective address for load/store
//  in_stdata      in   XLEN    store data (rs2 value)
//  in_dst         in   5       destination register
//  in_memread     in   1       instruction is a load
//  in_memwrite    in   1       instruction is a store
//  in_memsize     in   2       0=B 1=H 2=W 3=D
//  in_memunsign   in   1       zero-extend load (LBU/LHU/LWU)
//  dreq_valid     out  1       data-bus request
//  dreq_addr      out  ADDR_W  request address = in_aluout
//  dreq_size      out  2       = memsize
//  dreq_strobe    out  8       byte write enables; 0 for loads
//  dreq_data      out  XLEN    store data shifted to its byte lane
//  dresp_data_ok  in   1       transaction complete; dresp_data valid
//  dresp_data     in   XLEN    raw 64-bit aligned read data
//  out_valid      out  1       result valid to writeback
//  out_ready      in   1       writeback accepts
//  out_result     out  XLEN    load data (extended) or in_aluout
//  out_dst        out  5       captured in_dst
//  out_misalign   out  1       misaligned-access flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, except in_ready=1.
//  FSM IDLE / BUS / HOLD:
//   IDLE: in_ready=1. On in_valid, capture all in_* fields.
//     Load or store -> BUS. Otherwise -> HOLD with out_result=aluout.
//   BUS: in_ready=0. dreq_valid=1, and all dreq_* fields stay stable from the captured values.
//     On dresp_data_ok: close the request (dreq_valid=0 next cycle), form out_result, go to HOLD.
//   HOLD: out_valid=1. On out_ready, the result retires.
//     If in_valid is also high that cycle, capture the new input in the same cycle (bubble-free).
//     It then goes to BUS or HOLD as in IDLE. Otherwise -> IDLE.
//     in_ready = out_ready while in HOLD.
//  Latency: non-memory op = 1 cycle in->out_valid. Memory op = 1 + bus cycles (min 2 when data_ok
//   arrives the cycle after dreq_valid).
//  Lane/off = addr[2:0].
//   strobe: B=8'h01<<off, H=8'h03<<off, W=8'h0F<<off, D=8'hFF.
//   dreq_data = stdata << (8*off).
//  Load: shift dresp_data right by 8*off, truncate to size, then sign- or zero-extend to 64 bits.
//   D ignores memunsign.
//  memread and memwrite both set: treat as store.
//  Reset mid-BUS: immediately drop dreq_valid and return to IDLE. The aborted access is not retried.
//  dresp_data_ok outside BUS is ignored.
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined:
//   An address not aligned to its size (H:off[0], W:off[1:0], D:off[2:0] nonzero) never enters BUS.
//   The stage goes straight to HOLD with out_misalign=1 and out_result=aluout.
//  Undefined:
//   out_misalign is tied 0 and misaligned requests are issued as-is; the lane shift still applies.
// TESTING
//  1 Reset with in_valid=1 -> in_ready=1, out_valid=0, dreq_valid=0. Release -> capture on the first edge.
//  2 ALU op, aluout=64'h1234, dst=5, out_ready=1 -> next cycle out_valid=1, result=64'h1234, dst=5.
//     Back-to-back every cycle with no bubbles.
//  3 LB addr=..03, dresp_data=64'h0000_0000_80FF_0000 -> byte 0x80 -> result 64'hFFFF_FFFF_FFFF_FF80.
//     LBU at the same address -> 64'h80.
//  4 SH addr=..06, stdata=16'hBEEF -> strobe 8'hC0, dreq_data[63:48]=16'hBEEF.
//     With data_ok held off 3 cycles, in_ready=0 and dreq_* stay stable throughout.
//  5 Load completes while out_ready=0 for 4 cycles -> out_valid and result held, in_ready=0.
//     When out_ready rises with in_valid=1 -> retire and capture in the same cycle.
//  6 MEM_MISALIGN_CHECK_EN: LW addr=..02 -> no dreq_valid, out_misalign=1 after 1 cycle.
//     Without the macro -> request issued with strobe 0 and size 2.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage; one data-bus access per load/store, extends load data, registers result for writeback.
// Optional feature: define MEM_MISALIGN_CHECK_EN to flag misaligned accesses instead of issuing them.
module memory_stage #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_aluout,
  input  logic [XLEN-1:0]   in_stdata,
  input  logic [4:0]        in_dst,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [1:0]        in_memsize,
  input  logic              in_memunsign,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [4:0]        out_dst,
  output logic              out_misalign
);
  typedef enum logic [1:0] {IDLE, BUS, HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0] size_q, size_d;
  logic [7:0] strobe_q, strobe_d;
  logic [XLEN-1:0] wdata_q, wdata_d, result_q, result_d;
  logic [4:0] dst_q, dst_d;
  logic load_q, load_d, unsign_q, unsign_d, mis_q, mis_d;
  logic accept, is_mem, mis, sext;
  logic [2:0] off;
  logic [7:0] mask;
  logic [XLEN-1:0] sh, ld_ext;
  assign in_ready     = (state_q == IDLE) || (state_q == HOLD && out_ready);
  assign accept       = in_valid && in_ready;
  assign off          = in_aluout[2:0];
  assign is_mem       = in_memread || in_memwrite;
  assign mask         = in_memsize == 2'd0 ? 8'h01 : in_memsize == 2'd1 ? 8'h03 : 8'h0F;
`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = is_mem && (in_memsize == 2'd1 ? off[0] : in_memsize == 2'd2 ? |off[1:0] :
                          in_memsize == 2'd3 ? |off : 1'b0);
`else
  assign mis = 1'b0;
`endif
  assign sh           = dresp_data >> {addr_q[2:0], 3'b000};
  assign sext         = ~unsign_q;
  assign ld_ext       = size_q == 2'd0 ? {{56{sext & sh[7]}}, sh[7:0]} :
                        size_q == 2'd1 ? {{48{sext & sh[15]}}, sh[15:0]} :
                        size_q == 2'd2 ? {{32{sext & sh[31]}}, sh[31:0]} : sh;
  assign dreq_valid   = state_q == BUS;
  assign dreq_addr    = addr_q;
  assign dreq_size    = size_q;
  assign dreq_strobe  = strobe_q;
  assign dreq_data    = wdata_q;
  assign out_valid    = state_q == HOLD;
  assign out_result   = result_q;
  assign out_dst      = dst_q;
  assign out_misalign = mis_q;
  // Next state: capture on accept (including bubble-free capture while retiring), finish bus, or retire.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    dst_d    = dst_q;
    load_d   = load_q;
    unsign_d = unsign_q;
    mis_d    = mis_q;
    if (accept) begin
      state_d  = (is_mem && !mis) ? BUS : HOLD;
      addr_d   = in_aluout[ADDR_W-1:0];
      size_d   = in_memsize;
      strobe_d = in_memwrite ? (in_memsize == 2'd3 ? 8'hFF : mask << off) : 8'h00;
      wdata_d  = in_stdata << {off, 3'b000};
      result_d = in_aluout;
      dst_d    = in_dst;
      load_d   = in_memread && !in_memwrite;
      unsign_d = in_memunsign;
      mis_d    = mis;
    end else if (state_q == BUS && dresp_data_ok) begin
      state_d  = HOLD;
      result_d = load_q ? ld_ext : result_q;
    end else if (state_q == HOLD && out_ready) begin
      state_d  = IDLE;
    end
  end
  // State and captured fields; reset aborts any open bus access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      dst_q    <= '0;
      load_q   <= 1'b0;
      unsign_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      dst_q    <= dst_d;
      load_q   <= load_d;
      unsign_q <= unsign_d;
      mis_q    <= mis_d;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed table-driven checks of memory_stage plus multi-cycle corner sequences.
module tb_memory_stage;
  logic clk = 1'b0, reset = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [63:0] in_aluout = '0, in_stdata = '0;
  logic [4:0] in_dst = '0;
  logic in_memread = 1'b0, in_memwrite = 1'b0, in_memunsign = 1'b0;
  logic [1:0] in_memsize = '0;
  logic dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [1:0] dreq_size;
  logic [7:0] dreq_strobe;
  logic dresp_data_ok = 1'b0;
  logic [63:0] dresp_data = '0;
  logic out_valid, out_ready = 1'b1;
  logic [63:0] out_result;
  logic [4:0] out_dst;
  logic out_misalign;
  int n_checks = 0, n_fail = 0;

  memory_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluout(in_aluout), .in_stdata(in_stdata), .in_dst(in_dst),
    .in_memread(in_memread), .in_memwrite(in_memwrite), .in_memsize(in_memsize),
    .in_memunsign(in_memunsign), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_dst(out_dst),
    .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] st;
    logic [4:0]  dst;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        un;
    logic [63:0] rdata;
    int          dly;
    logic [63:0] exp_res;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] alu, input logic [63:0] st, input logic [4:0] dst,
                       input logic rd, input logic wr, input logic [1:0] sz, input logic un);
    in_valid = 1'b1; in_aluout = alu; in_stdata = st; in_dst = dst;
    in_memread = rd; in_memwrite = wr; in_memsize = sz; in_memunsign = un;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({t, ".in_ready"}, 64'(in_ready), 64'd1);
    drive(v.alu, v.st, v.dst, v.rd, v.wr, v.sz, v.un);
    @(negedge clk);
    in_valid = 1'b0;
    if (v.rd || v.wr) begin
      for (int d = 0; d <= v.dly; d++) begin
        chk({t, ".dreq_valid"}, 64'(dreq_valid), 64'd1);
        chk({t, ".in_ready_bus"}, 64'(in_ready), 64'd0);
        chk({t, ".dreq_addr"}, dreq_addr, v.alu);
        chk({t, ".dreq_size"}, 64'(dreq_size), 64'(v.sz));
        chk({t, ".dreq_strobe"}, 64'(dreq_strobe), 64'(v.exp_strb));
        if (v.wr) chk({t, ".dreq_data"}, dreq_data, v.exp_wdata);
        if (d == v.dly) begin
          dresp_data_ok = 1'b1;
          dresp_data = v.rdata;
        end
        @(negedge clk);
      end
      dresp_data_ok = 1'b0;
      chk({t, ".dreq_closed"}, 64'(dreq_valid), 64'd0);
    end
    chk({t, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({t, ".out_result"}, out_result, v.exp_res);
    chk({t, ".out_dst"}, 64'(out_dst), 64'(v.dst));
    chk({t, ".out_misalign"}, 64'(out_misalign), 64'd0);
  endtask

  initial begin
    //          alu                     st                     dst  rd wr sz un rdata                  dly result                 strb   wdata
    vecs[0]  = '{64'h1234,              64'h0,                 5'd5, 0, 0, 0, 0, 64'h0,                 0, 64'h1234,              8'h00, 64'h0};
    vecs[1]  = '{64'h1000_0003,         64'h0,                 5'd6, 1, 0, 0, 0, 64'h0000_0000_80FF_0000, 0, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0};
    vecs[2]  = '{64'h1000_0003,         64'h0,                 5'd7, 1, 0, 0, 1, 64'h0000_0000_80FF_0000, 1, 64'h80,                8'h00, 64'h0};
    vecs[3]  = '{64'h1000_0006,         64'hBEEF,              5'd8, 0, 1, 1, 0, 64'h0,                 3, 64'h1000_0006,         8'hC0, 64'hBEEF_0000_0000_0000};
    vecs[4]  = '{64'h2000_0002,         64'h0,                 5'd9, 1, 0, 1, 0, 64'h0000_0000_8001_0000, 0, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0};
    vecs[5]  = '{64'h2000_0004,         64'h0,                 5'd10, 1, 0, 2, 1, 64'hDEAD_BEEF_0000_0000, 2, 64'hDEAD_BEEF,          8'h00, 64'h0};
    vecs[6]  = '{64'h2000_0004,         64'h0,                 5'd11, 1, 0, 2, 0, 64'hDEAD_BEEF_0000_0000, 0, 64'hFFFF_FFFF_DEAD_BEEF, 8'h00, 64'h0};
    vecs[7]  = '{64'h3000_0000,         64'h0,                 5'd12, 1, 0, 3, 1, 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0};
    vecs[8]  = '{64'h3000_0008,         64'h1122_3344_5566_7788, 5'd13, 0, 1, 3, 0, 64'h0,               1, 64'h3000_0008,         8'hFF, 64'h1122_3344_5566_7788};
    vecs[9]  = '{64'h4000_0005,         64'hAB,                5'd14, 0, 1, 0, 0, 64'h0,                 0, 64'h4000_0005,         8'h20, 64'h0000_AB00_0000_0000};
    vecs[10] = '{64'h4000_0004,         64'hDEAD_BEEF,         5'd15, 0, 1, 2, 0, 64'h0,                 0, 64'h4000_0004,         8'hF0, 64'hDEAD_BEEF_0000_0000};
    vecs[11] = '{64'h4000_0001,         64'h55,                5'd16, 1, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h4000_0001,       8'h02, 64'h5500};

    // Reset held with in_valid high: nothing captured, idle outputs.
    drive(64'h77, 64'h0, 5'd3, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst.out_result", out_result, 64'd0);
    chk("rst.dreq_addr", dreq_addr, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst.first_edge_valid", 64'(out_valid), 64'd1);
    chk("rst.first_edge_result", out_result, 64'h77);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back ALU ops every cycle with out_ready high.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        chk("b2b.out_valid", 64'(out_valid), 64'd1);
        chk("b2b.out_result", out_result, 64'h500 + 64'(i - 1));
        chk("b2b.out_dst", 64'(out_dst), 64'(i + 19));
      end
      chk("b2b.in_ready", 64'(in_ready), 64'd1);
      if (i < 4) drive(64'h500 + 64'(i), 64'h0, 5'(i + 20), 0, 0, 0, 0);
      else in_valid = 1'b0;
      @(negedge clk);
    end

    // Load completes while writeback stalls; retire and capture in the same cycle.
    drive(64'h5000_0001, 64'h0, 5'd21, 1, 0, 0, 1);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    dresp_data_ok = 1'b1;
    dresp_data = 64'h0000_0000_0000_C300;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall.out_valid", 64'(out_valid), 64'd1);
      chk("stall.out_result", out_result, 64'hC3);
      chk("stall.in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drive(64'h9ABC, 64'h0, 5'd22, 0, 0, 0, 0);
    #1;
    chk("stall.release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall.next_valid", 64'(out_valid), 64'd1);
    chk("stall.next_result", out_result, 64'h9ABC);
    chk("stall.next_dst", 64'(out_dst), 64'd22);
    @(negedge clk);

    // Reset during BUS drops the request; a late data_ok is ignored.
    drive(64'h6000_0000, 64'h0, 5'd23, 1, 0, 3, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort.dreq_valid_before", 64'(dreq_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort.dreq_valid_after", 64'(dreq_valid), 64'd0);
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data = 64'hFFFF;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    chk("abort.ignored_ok_valid", 64'(out_valid), 64'd0);
    chk("abort.ignored_ok_dreq", 64'(dreq_valid), 64'd0);

    // Misaligned LW at offset 2.
    drive(64'h7000_0002, 64'h0, 5'd24, 1, 0, 2, 0);
    @(negedge clk);
    in_valid = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    chk("mis.dreq_valid", 64'(dreq_valid), 64'd0);
    chk("mis.out_valid", 64'(out_valid), 64'd1);
    chk("mis.out_misalign", 64'(out_misalign), 64'd1);
    chk("mis.out_result", out_result, 64'h7000_0002);
`else
    chk("mis.dreq_valid", 64'(dreq_valid), 64'd1);
    chk("mis.dreq_strobe", 64'(dreq_strobe), 64'd0);
    chk("mis.dreq_size", 64'(dreq_size), 64'd2);
    chk("mis.dreq_addr", dreq_addr, 64'h7000_0002);
    dresp_data_ok = 1'b1;
    dresp_data = 64'h1111_2222_3333_4444;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    chk("mis.out_result", out_result, 64'h2222_3333);
    chk("mis.out_misalign", 64'(out_misalign), 64'd0);
`endif
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
